// File: rtl/cache_pkg.sv
// cache_pkg: FSM state type and parameter-derivation helpers shared by the cache controller.
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, MISS_RESP, FLUSH} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int tag_w(input int addr_w, input int index_w);
    return addr_w - index_w;
  endfunction
  function automatic int sets(input int index_w);
    return 1 << index_w;
  endfunction
  function automatic int way_w(input int ways);
    return ways > 1 ? clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: lowest invalid way of a set, else that set's round-robin pointer.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  localparam int WAY_W = way_w(WAYS)
)(
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] ptr,
  output logic [WAY_W-1:0] victim
);
  always_comb begin
    victim = ptr;
    for (int i = WAYS - 1; i >= 0; i--) if (!valid[i]) victim = WAY_W'(i);
  end
endmodule

// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc: N-way set-associative cache controller with round-robin refill and flush.
// Define CACHE_PERF_CNT_EN to add saturating hit_count/access_count outputs.
module cache_ctrl_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int INDEX_W = 10,
  parameter int WAYS = 2,
  localparam int WAY_W = way_w(WAYS)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [WAY_W-1:0]   resp_way,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  output logic               data_we,
  output logic [INDEX_W-1:0] data_index,
  output logic [WAY_W-1:0]   data_way,
  input  logic               flush,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]        hit_count,
  output logic [31:0]        access_count,
`endif
  output logic               flush_done
);
  localparam int TAG_W = tag_w(ADDR_W, INDEX_W);
  localparam int SETS = sets(INDEX_W);
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic [WAY_W-1:0] victim_q, victim, hit_way;
  logic [INDEX_W-1:0] flush_cnt, idx;
  logic [TAG_W-1:0] tag;
  logic [WAYS-1:0] valid [SETS];
  logic [WAY_W-1:0] ptr [SETS];
  logic [TAG_W-1:0] tags [SETS][WAYS];
  logic hit;
  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_W-1:INDEX_W];
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
  end
  cache_victim_sel #(.WAYS(WAYS)) u_victim (
    .valid  (valid[idx]),
    .ptr    (ptr[idx]),
    .victim (victim)
  );
  // Outputs decode directly from state so a reset mid-miss drops them at once.
  assign req_ready = state == IDLE && !flush;
  assign resp_hit = state == LOOKUP && hit;
  assign resp_valid = resp_hit || state == MISS_RESP;
  assign resp_way = state == LOOKUP ? hit_way : state == MISS_RESP ? victim_q : '0;
  assign mem_req_valid = state == MISS_REQ;
  assign mem_req_addr = addr_q;
  assign data_we = state == MISS_WAIT && mem_rsp_valid;
  assign data_index = idx;
  assign data_way = victim_q;
  assign flush_done = state == FLUSH && flush_cnt == '1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      victim_q <= '0;
      flush_cnt <= '0;
      for (int i = 0; i < SETS; i++) begin
        valid[i] <= '0;
        ptr[i] <= '0;
      end
    end else
      case (state)
        IDLE:
          if (flush) begin
            state <= FLUSH;
            flush_cnt <= '0;
          end else if (req_valid) begin
            addr_q <= req_addr;
            state <= LOOKUP;
          end
        LOOKUP:
          if (hit) state <= IDLE;
          else begin
            victim_q <= victim;
            state <= MISS_REQ;
          end
        MISS_REQ: if (mem_req_ready) state <= MISS_WAIT;
        MISS_WAIT:
          if (mem_rsp_valid) begin
            valid[idx][victim_q] <= 1'b1;
            // Filling an invalid way that is not the pointer leaves rotation untouched.
            if (victim_q == ptr[idx]) ptr[idx] <= ptr[idx] == WAY_W'(WAYS - 1) ? '0 : ptr[idx] + WAY_W'(1);
            state <= MISS_RESP;
          end
        MISS_RESP: state <= IDLE;
        FLUSH: begin
          valid[flush_cnt] <= '0;
          ptr[flush_cnt] <= '0;
          flush_cnt <= flush_cnt + INDEX_W'(1);
          if (flush_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  always_ff @(posedge clk) if (data_we) tags[idx][victim_q] <= tag;
`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_count <= '0;
      access_count <= '0;
    end else if (resp_valid) begin
      access_count <= access_count + 32'(access_count != '1);
      hit_count <= hit_count + 32'(resp_hit && hit_count != '1);
    end
`endif
endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// tb_cache_ctrl_assoc: directed plus randomized requests checked against a set/way reference model.
module tb_cache_ctrl_assoc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [14:0] req_addr = '0;
  logic resp_valid, resp_hit;
  logic [0:0] resp_way;
  logic mem_req_valid, mem_req_ready = 1'b0;
  logic [14:0] mem_req_addr;
  logic mem_rsp_valid = 1'b0;
  logic data_we;
  logic [9:0] data_index;
  logic [0:0] data_way;
  logic flush = 1'b0, flush_done;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, access_count;
`endif
  int n_checks = 0, n_fail = 0;
  int m_acc = 0, m_hit = 0;
  logic mvalid [1024][2];
  logic [4:0] mtag [1024][2];
  int mptr [1024];

  always #5 clk = ~clk;

  cache_ctrl_assoc dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_way      (resp_way),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .data_we       (data_we),
    .data_index    (data_index),
    .data_way      (data_way),
    .flush         (flush),
`ifdef CACHE_PERF_CNT_EN
    .hit_count     (hit_count),
    .access_count  (access_count),
`endif
    .flush_done    (flush_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) begin
      mvalid[i][0] = 1'b0;
      mvalid[i][1] = 1'b0;
      mptr[i] = 0;
    end
  endtask

  task automatic check_perf();
`ifdef CACHE_PERF_CNT_EN
    check("access_count", access_count, m_acc);
    check("hit_count", hit_count, m_hit);
`endif
  endtask

  // One request; rdly = cycles memory withholds req_ready, sdly = cycles before refill data.
  task automatic do_req(input logic [14:0] a, input int rdly, input int sdly);
    int s, way, vic;
    logic [4:0] t;
    bit hit;
    s = int'(a[9:0]);
    t = a[14:10];
    hit = 1'b0;
    way = 0;
    for (int w = 1; w >= 0; w--) if (mvalid[s][w] && mtag[s][w] == t) begin hit = 1'b1; way = w; end
    vic = mptr[s];
    for (int w = 1; w >= 0; w--) if (!mvalid[s][w]) vic = w;
    check("idle_ready", 32'(req_ready), 1);
    check("idle_resp", 32'(resp_valid), 0);
    req_valid = 1'b1;
    req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = 15'($urandom);
    m_acc++;
    if (hit) begin
      m_hit++;
      check("hit_valid", 32'(resp_valid), 1);
      check("hit_flag", 32'(resp_hit), 1);
      check("hit_way", 32'(resp_way), way);
      check("hit_no_mem", 32'(mem_req_valid), 0);
    end else begin
      check("lookup_no_resp", 32'(resp_valid), 0);
      @(negedge clk);
      for (int i = 0; i <= rdly; i++) begin
        check("mreq_valid", 32'(mem_req_valid), 1);
        check("mreq_addr", 32'(mem_req_addr), 32'(a));
        mem_rsp_valid = ($urandom_range(0, 1) == 1);
        #1 check("early_rsp_no_we", 32'(data_we), 0);
        mem_req_ready = (i == rdly);
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < sdly; i++) begin
        #1 check("wait_no_we", 32'(data_we), 0);
        check("wait_mreq_low", 32'(mem_req_valid), 0);
        @(negedge clk);
      end
      mem_rsp_valid = 1'b1;
      #1;
      check("fill_we", 32'(data_we), 1);
      check("fill_index", 32'(data_index), s);
      check("fill_way", 32'(data_way), vic);
      check("fill_no_resp", 32'(resp_valid), 0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check("miss_valid", 32'(resp_valid), 1);
      check("miss_flag", 32'(resp_hit), 0);
      check("miss_way", 32'(resp_way), vic);
      mvalid[s][vic] = 1'b1;
      mtag[s][vic] = t;
      if (vic == mptr[s]) mptr[s] = (mptr[s] + 1) % 2;
    end
    @(negedge clk);
  endtask

  task automatic do_flush();
    int n;
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 15'h0805;
    #1 check("flush_prio_ready", 32'(req_ready), 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("flush_no_lookup", 32'(resp_valid), 0);
    n = 1;
    while (!flush_done && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("flush_len", n, 1024);
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_ready", 32'(req_ready), 1);
    check("flush_done_pulse", 32'(flush_done), 0);
    model_clear();
    check_perf();
  endtask

  // Abandons a miss with reset: stage 0 = while requesting memory, 1 = while awaiting data.
  task automatic reset_mid(input logic [14:0] a, input int stage);
    req_valid = 1'b1;
    req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rm_mreq", 32'(mem_req_valid), 1);
    if (stage == 1) begin
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rm_mreq_drop", 32'(mem_req_valid), 0);
    check("rm_ready", 32'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_acc = 0;
    m_hit = 0;
    mem_rsp_valid = 1'b1;
    #1 check("rm_late_no_we", 32'(data_we), 0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check_perf();
  endtask

  initial begin
    logic [14:0] ra;
    int sp;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_hit", 32'(resp_hit), 0);
    check("rst_resp_way", 32'(resp_way), 0);
    check("rst_mreq", 32'(mem_req_valid), 0);
    check("rst_mreq_addr", 32'(mem_req_addr), 0);
    check("rst_we", 32'(data_we), 0);
    check("rst_flush_done", 32'(flush_done), 0);
    rst = 1'b0;
    @(negedge clk);
    do_req(15'h0405, 0, 0);
    do_req(15'h0405, 0, 0);
    do_req(15'h0805, 0, 0);
    do_req(15'h0C05, 0, 0);
    do_req(15'h0405, 0, 0);
    do_req(15'h0805, 0, 0);
    check_perf();
    do_flush();
    do_req(15'h0805, 0, 0);
    reset_mid(15'h0405, 1);
    do_req(15'h0405, 0, 0);
    reset_mid(15'h0C07, 0);
    do_req(15'h0C07, 1, 2);
    for (int k = 0; k < 300; k++) begin
      sp = $urandom_range(0, 3);
      ra = {5'($urandom_range(0, 3)), sp == 0 ? 10'd0 : sp == 1 ? 10'd5 : sp == 2 ? 10'd1023 : 10'($urandom)};
      do_req(ra, $urandom_range(0, 2), $urandom_range(0, 2));
      if (k == 150) do_flush();
    end
    check_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
